rob: RTL and testbench

//  Reorder buffer: in-order tracking of renamed instructions from dispatch to retire.

---
 rtl/rob_pkg.sv | 51 +++++
 rtl/rob_if.sv | 33 +++
 rtl/rob_retire_sel.sv | 48 ++++
 rtl/rob.sv | 144 ++++++++++++++
 tb/tb_rob.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared ROB parameters, bus payloads and the stored entry format.
// Sizes are for the production core. The block's entry count can be overridden per instance.
package rob_pkg;

    localparam int unsigned WIDTH     = 2;
    localparam int unsigned ROB_SIZE  = 32;
    localparam int unsigned PRF_SIZE  = 64;
    localparam int unsigned FL_SIZE   = 32;
    localparam int unsigned ARCH_REGS = 32;

    localparam int unsigned PW  = $clog2(PRF_SIZE);
    localparam int unsigned AW  = $clog2(ARCH_REGS);
    localparam int unsigned FLW = $clog2(FL_SIZE);
    localparam int unsigned NRW = $clog2(WIDTH + 1);

    typedef struct packed {
        logic          retire_en;
        logic [PW-1:0] t_hold;
    } rob_fl_packet_t;

    typedef struct packed {
        logic [PW-1:0]  t;
        logic [PW-1:0]  t_old;
        logic [AW-1:0]  dest_arch;
        logic           has_dest;
        logic           is_branch;
        logic [FLW-1:0] fl_head_next;
    } rob_disp_packet_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest_arch;
        logic [PW-1:0] t;
    } rob_retire_packet_t;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic             mispred;
        rob_disp_packet_t pkt;
    } rob_entry_t;

    // Number of set bits in a per-slot enable vector.
    function automatic logic [NRW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [NRW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) r = r + NRW'(v[i]);
        return r;
    endfunction

endpackage

// File: rtl/rob_if.sv
// ROB bus: dispatch/rename, CDB completion, freelist and arch-map retire, and rollback.
// The master is the surrounding pipeline and the slave is the ROB.
interface rob_if
    import rob_pkg::*;
#(
    parameter int unsigned N = ROB_SIZE
) ();
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    logic               [WIDTH-1:0]         disp_en;
    rob_disp_packet_t   [WIDTH-1:0]         disp_pack;
    logic               [WIDTH-1:0][IW-1:0] disp_rob_idx;
    logic               [CW-1:0]            free_slots;
    logic               [WIDTH-1:0]         cdb_en;
    logic               [WIDTH-1:0][IW-1:0] cdb_rob_idx;
    logic               [WIDTH-1:0]         cdb_mispredict;
    rob_fl_packet_t     [WIDTH-1:0]         rob_pack;
    rob_retire_packet_t [WIDTH-1:0]         retire_pack;
    logic                                   rollback_en;
    logic               [FLW-1:0]           recover_head;

    modport master (
        output disp_en, disp_pack, cdb_en, cdb_rob_idx, cdb_mispredict,
        input  disp_rob_idx, free_slots, rob_pack, retire_pack, rollback_en, recover_head
    );

    modport slave (
        input  disp_en, disp_pack, cdb_en, cdb_rob_idx, cdb_mispredict,
        output disp_rob_idx, free_slots, rob_pack, retire_pack, rollback_en, recover_head
    );

endinterface

// File: rtl/rob_retire_sel.sv
// Retire selection: walks up to WIDTH entries from head and stops at the first one that is not done.
// A mispredicted branch retires by itself, and only in slot 0.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter  int unsigned N  = ROB_SIZE,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [IW-1:0]    head_i,
    input  logic [N-1:0]     valid_i,
    input  logic [N-1:0]     done_i,
    input  logic [N-1:0]     mispred_i,
    output logic [WIDTH-1:0] mask_o,
    output logic [NRW-1:0]   nret_o,
    output logic             rollback_o
);

    logic          stop;
    logic [IW-1:0] idx;

    always_comb begin
        mask_o     = '0;
        nret_o     = '0;
        rollback_o = 1'b0;
        stop       = 1'b0;
        idx        = head_i;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            idx = head_i + IW'(b);
            if (!stop) begin
                if (!(valid_i[idx] && done_i[idx])) begin
                    stop = 1'b1;
                end else if (mispred_i[idx]) begin
                    // Older entries must drain first, so a branch in a later slot waits a cycle.
                    if (b == 0) begin
                        mask_o[0]  = 1'b1;
                        nret_o     = NRW'(1);
                        rollback_o = 1'b1;
                    end
                    stop = 1'b1;
                end else begin
                    mask_o[b] = 1'b1;
                    nret_o    = nret_o + NRW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer: a circular buffer that keeps renamed instructions in program order.
// It returns T_old to the freelist and retire data to the arch map, and it drives rollback on a mispredict.
module rob
    import rob_pkg::*;
#(
    parameter int unsigned N = ROB_SIZE
) (
    input  logic clock,
    input  logic reset,
    rob_if.slave bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    rob_entry_t ent_q [N];
    rob_entry_t ent_d [N];
    logic [IW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0]              free_slots;
    logic [N-1:0]               valid_v, done_v, mispred_v;
    logic [WIDTH-1:0]           ret_mask;
    logic [NRW-1:0]             nret, ndisp, ndisp_eff;
    logic                       rollback, disp_ok;
    logic [WIDTH-1:0][IW-1:0]   disp_idx, slot_idx;
    logic [IW-1:0]              disp_off;

    assign free_slots = CW'(N) - count_q;
    assign ndisp      = popcnt(bus.disp_en);
    assign disp_ok    = CW'(ndisp) <= free_slots;
    assign ndisp_eff  = disp_ok ? ndisp : '0;

    always_comb begin
        valid_v   = '0;
        done_v    = '0;
        mispred_v = '0;
        for (int unsigned i = 0; i < N; i++) begin
            valid_v[i]   = ent_q[i].valid;
            done_v[i]    = ent_q[i].done;
            mispred_v[i] = ent_q[i].mispred;
        end
    end

    // Active dispatch slots are packed onto consecutive entries starting at tail.
    always_comb begin
        disp_off = '0;
        disp_idx = '0;
        slot_idx = '0;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            disp_idx[c] = tail_q + disp_off;
            slot_idx[c] = head_q + IW'(c);
            if (bus.disp_en[c]) disp_off = disp_off + IW'(1);
        end
    end

    rob_retire_sel #(.N(N)) u_retire_sel (
        .head_i    (head_q),
        .valid_i   (valid_v),
        .done_i    (done_v),
        .mispred_i (mispred_v),
        .mask_o    (ret_mask),
        .nret_o    (nret),
        .rollback_o(rollback)
    );

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rollback) begin
            for (int unsigned i = 0; i < N; i++) begin
                ent_d[i].valid   = 1'b0;
                ent_d[i].done    = 1'b0;
                ent_d[i].mispred = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int unsigned c = 0; c < WIDTH; c++) begin
                if (bus.cdb_en[c] && ent_q[bus.cdb_rob_idx[c]].valid) begin
                    ent_d[bus.cdb_rob_idx[c]].done = 1'b1;
                    if (bus.cdb_mispredict[c]) ent_d[bus.cdb_rob_idx[c]].mispred = 1'b1;
                end
            end
            for (int unsigned b = 0; b < WIDTH; b++) begin
                if (ret_mask[b]) begin
                    ent_d[slot_idx[b]].valid   = 1'b0;
                    ent_d[slot_idx[b]].done    = 1'b0;
                    ent_d[slot_idx[b]].mispred = 1'b0;
                end
            end
            if (disp_ok) begin
                for (int unsigned c = 0; c < WIDTH; c++) begin
                    if (bus.disp_en[c]) begin
                        ent_d[disp_idx[c]] = '{valid: 1'b1, done: 1'b0, mispred: 1'b0,
                                               pkt: bus.disp_pack[c]};
                    end
                end
            end
            head_d  = head_q + IW'(nret);
            tail_d  = tail_q + IW'(ndisp_eff);
            count_d = count_q + CW'(ndisp_eff) - CW'(nret);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < N; i++) ent_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

    // Retire outputs. A rollback cycle hands no physical registers back to the freelist.
    always_comb begin
        bus.rob_pack     = '0;
        bus.retire_pack  = '0;
        bus.rollback_en  = rollback;
        bus.recover_head = rollback ? ent_q[head_q].pkt.fl_head_next : '0;
        bus.free_slots   = free_slots;
        bus.disp_rob_idx = disp_idx;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (ret_mask[b]) begin
                bus.rob_pack[b].retire_en     = ent_q[slot_idx[b]].pkt.has_dest & ~rollback;
                bus.rob_pack[b].t_hold        = rollback ? '0 : ent_q[slot_idx[b]].pkt.t_old;
                bus.retire_pack[b].valid      = ent_q[slot_idx[b]].pkt.has_dest;
                bus.retire_pack[b].dest_arch  = ent_q[slot_idx[b]].pkt.dest_arch;
                bus.retire_pack[b].t          = ent_q[slot_idx[b]].pkt.t;
            end
        end
    end

    a_disp_overflow: assert property (@(posedge clock) disable iff (reset)
                                      CW'(ndisp) <= free_slots);

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob (WIDTH=2, 8 entries): dispatch table, directed sequences,
// and a T_old scoreboard that is checked whenever the freelist port signals a retire.
module tb_rob;
    import rob_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_if #(.N(N)) bus ();
    rob #(.N(N)) dut (.clock(clk), .reset(rst), .bus(bus));

    typedef struct {
        logic [PW-1:0] t_old;
        logic [PW-1:0] t;
        logic [AW-1:0] dest;
    } exp_ret_t;

    typedef struct {
        logic [1:0]    en;
        logic [IW-1:0] idx0;
        logic [IW-1:0] idx1;
        logic [3:0]    free;
    } vec_t;

    exp_ret_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rob_disp_packet_t mk(input int t, input int t_old, input int dest,
                                            input bit hd, input bit br, input int fl);
        rob_disp_packet_t p;
        p.t            = PW'(t);
        p.t_old        = PW'(t_old);
        p.dest_arch    = AW'(dest);
        p.has_dest     = hd;
        p.is_branch    = br;
        p.fl_head_next = FLW'(fl);
        return p;
    endfunction

    task automatic idle();
        bus.disp_en        = '0;
        bus.disp_pack      = '0;
        bus.cdb_en         = '0;
        bus.cdb_rob_idx    = '0;
        bus.cdb_mispredict = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input rob_disp_packet_t p);
        exp_ret_t e;
        e.t_old = p.t_old;
        e.t     = p.t;
        e.dest  = p.dest_arch;
        exp_q.push_back(e);
    endtask

    task automatic disp(input logic [1:0] en, input rob_disp_packet_t p0, input rob_disp_packet_t p1);
        bus.disp_en      = en;
        bus.disp_pack[0] = p0;
        bus.disp_pack[1] = p1;
        if (en[0] && p0.has_dest) push_exp(p0);
        if (en[1] && p1.has_dest) push_exp(p1);
    endtask

    task automatic cmpl(input logic [1:0] en, input int i0, input int i1, input logic [1:0] mis);
        bus.cdb_en         = en;
        bus.cdb_rob_idx[0] = IW'(i0);
        bus.cdb_rob_idx[1] = IW'(i1);
        bus.cdb_mispredict = mis;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: every freelist retire must match the oldest outstanding destination.
    always @(negedge clk) begin
        exp_ret_t e;
        if (rst === 1'b0) begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                if (bus.rob_pack[b].retire_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_retire: slot %0d t_hold %0d, none expected",
                                 b, bus.rob_pack[b].t_hold);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_t_hold", 32'(bus.rob_pack[b].t_hold), 32'(e.t_old));
                        chk("sb_retire_valid", 32'(bus.retire_pack[b].valid), 32'd1);
                        chk("sb_retire_t", 32'(bus.retire_pack[b].t), 32'(e.t));
                        chk("sb_retire_dest", 32'(bus.retire_pack[b].dest_arch), 32'(e.dest));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{2'b11, 3'd0, 3'd1, 4'd6};
        tbl[1] = '{2'b10, 3'd2, 3'd2, 4'd5};
        tbl[2] = '{2'b01, 3'd3, 3'd4, 4'd4};
        tbl[3] = '{2'b00, 3'd4, 3'd4, 4'd4};
        tbl[4] = '{2'b11, 3'd4, 3'd5, 4'd2};
        tbl[5] = '{2'b11, 3'd6, 3'd7, 4'd0};

        do_reset();
        #1;
        chk("rst_free", 32'(bus.free_slots), 32'd8);
        chk("rst_rollback", 32'(bus.rollback_en), 32'd0);
        chk("rst_recover", 32'(bus.recover_head), 32'd0);
        chk("rst_ret0", 32'(bus.rob_pack[0].retire_en), 32'd0);
        chk("rst_ret1", 32'(bus.rob_pack[1].retire_en), 32'd0);
        chk("rst_idx0", 32'(bus.disp_rob_idx[0]), 32'd0);

        // Dispatch-pattern table: check index compaction and free_slots.
        for (int i = 0; i < 6; i++) begin
            disp(tbl[i].en, mk(2*i+1, 2*i+40, 1, 1, 0, 0), mk(2*i+2, 2*i+41, 2, 1, 0, 0));
            #1;
            chk("tbl_idx0", 32'(bus.disp_rob_idx[0]), 32'(tbl[i].idx0));
            chk("tbl_idx1", 32'(bus.disp_rob_idx[1]), 32'(tbl[i].idx1));
            tick();
            idle();
            chk("tbl_free", 32'(bus.free_slots), 32'(tbl[i].free));
        end
        do_reset();
        #1;
        chk("rst2_free", 32'(bus.free_slots), 32'd8);

        // Dispatch on slot 1 only, then complete and retire it.
        disp(2'b10, mk(0, 0, 0, 0, 0, 0), mk(21, 33, 3, 1, 0, 0));
        #1;
        chk("compact_idx1", 32'(bus.disp_rob_idx[1]), 32'd0);
        tick(); idle();
        chk("single_free_disp", 32'(bus.free_slots), 32'd7);
        cmpl(2'b01, 0, 0, 2'b00);
        tick(); idle();
        chk("single_ret_en", 32'(bus.rob_pack[0].retire_en), 32'd1);
        chk("single_t_hold", 32'(bus.rob_pack[0].t_hold), 32'd33);
        chk("single_ret1_off", 32'(bus.rob_pack[1].retire_en), 32'd0);
        chk("single_free_pre", 32'(bus.free_slots), 32'd7);
        tick();
        chk("single_free_post", 32'(bus.free_slots), 32'd8);

        // Out-of-order completion: the younger entry completes first.
        disp(2'b11, mk(22, 50, 4, 1, 0, 0), mk(23, 51, 5, 1, 0, 0));
        #1;
        chk("ooo_idx0", 32'(bus.disp_rob_idx[0]), 32'd1);
        chk("ooo_idx1", 32'(bus.disp_rob_idx[1]), 32'd2);
        tick(); idle();
        cmpl(2'b01, 2, 0, 2'b00);
        tick(); idle();
        chk("ooo_wait", 32'(bus.rob_pack[0].retire_en), 32'd0);
        cmpl(2'b01, 1, 0, 2'b00);
        tick(); idle();
        chk("ooo_ret0", 32'(bus.rob_pack[0].retire_en), 32'd1);
        chk("ooo_hold0", 32'(bus.rob_pack[0].t_hold), 32'd50);
        chk("ooo_ret1", 32'(bus.rob_pack[1].retire_en), 32'd1);
        chk("ooo_hold1", 32'(bus.rob_pack[1].t_hold), 32'd51);
        tick();
        chk("ooo_free", 32'(bus.free_slots), 32'd8);

        // Fill from head=3, so the tail wraps from 7 to 0. Then dispatch and retire in the same cycle.
        for (int k = 0; k < 4; k++) begin
            disp(2'b11, mk(30+2*k, 60+2*k, 6, 1, 0, 0), mk(31+2*k, 61+2*k, 7, 1, 0, 0));
            #1;
            chk("fill_idx0", 32'(bus.disp_rob_idx[0]), 32'((3 + 2*k) % 8));
            chk("fill_idx1", 32'(bus.disp_rob_idx[1]), 32'((4 + 2*k) % 8));
            tick(); idle();
        end
        chk("full_free", 32'(bus.free_slots), 32'd0);
        cmpl(2'b11, 1, 2, 2'b00); tick();
        cmpl(2'b11, 7, 0, 2'b00); tick();
        cmpl(2'b11, 5, 6, 2'b00); tick();
        cmpl(2'b11, 3, 4, 2'b00); tick(); idle();
        chk("full_done_free", 32'(bus.free_slots), 32'd0);
        chk("full_done_ret", 32'(bus.rob_pack[0].retire_en), 32'd1);
        tick();
        chk("after_ret_free", 32'(bus.free_slots), 32'd2);
        disp(2'b11, mk(40, 68, 8, 1, 0, 0), mk(41, 69, 9, 1, 0, 0));
        #1;
        chk("wrap_idx0", 32'(bus.disp_rob_idx[0]), 32'd3);
        chk("wrap_idx1", 32'(bus.disp_rob_idx[1]), 32'd4);
        tick(); idle();
        chk("disp_ret_count", 32'(bus.free_slots), 32'd2);
        cmpl(2'b11, 3, 4, 2'b00);
        tick(); idle();
        for (int k = 0; k < 10 && bus.free_slots != 4'd8; k++) tick();
        chk("drain_free", 32'(bus.free_slots), 32'd8);

        // Mispredicted branch at idx2: idx0 and idx1 retire first, then rollback.
        do_reset();
        disp(2'b11, mk(1, 70, 1, 1, 0, 0), mk(2, 71, 2, 1, 0, 0));
        tick(); idle();
        disp(2'b01, mk(3, 0, 0, 0, 1, 5), mk(0, 0, 0, 0, 0, 0));
        #1;
        chk("br_idx", 32'(bus.disp_rob_idx[0]), 32'd2);
        tick(); idle();
        cmpl(2'b11, 0, 1, 2'b00);
        tick(); idle();
        chk("br_old_ret0", 32'(bus.rob_pack[0].retire_en), 32'd1);
        chk("br_old_ret1", 32'(bus.rob_pack[1].retire_en), 32'd1);
        chk("br_no_rb_yet", 32'(bus.rollback_en), 32'd0);
        cmpl(2'b01, 2, 0, 2'b01);
        tick(); idle();
        chk("rb_en", 32'(bus.rollback_en), 32'd1);
        chk("rb_head", 32'(bus.recover_head), 32'd5);
        chk("rb_ret0_off", 32'(bus.rob_pack[0].retire_en), 32'd0);
        chk("rb_ret1_off", 32'(bus.rob_pack[1].retire_en), 32'd0);
        // Dispatch in the same cycle as the rollback; it must be dropped.
        bus.disp_en      = 2'b11;
        bus.disp_pack[0] = mk(9, 90, 3, 1, 0, 0);
        bus.disp_pack[1] = mk(10, 91, 4, 1, 0, 0);
        tick(); idle();
        #1;
        chk("rb_after_en", 32'(bus.rollback_en), 32'd0);
        chk("rb_after_free", 32'(bus.free_slots), 32'd8);
        chk("rb_after_tail", 32'(bus.disp_rob_idx[0]), 32'd0);

        // Reset while entries are done and ready to retire.
        disp(2'b11, mk(5, 80, 1, 1, 0, 0), mk(6, 81, 2, 1, 0, 0));
        tick(); idle();
        cmpl(2'b11, 0, 1, 2'b00);
        tick(); idle();
        chk("pre_rst_ret", 32'(bus.rob_pack[0].retire_en), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_done_ret0", 32'(bus.rob_pack[0].retire_en), 32'd0);
        chk("rst_done_ret1", 32'(bus.rob_pack[1].retire_en), 32'd0);
        chk("rst_done_free", 32'(bus.free_slots), 32'd8);
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
